// File: rtl/onehot_drain_encoder.sv
// Accepts a WIDTH-bit vector and streams out the index of every set bit,
// one valid/ready beat per bit; an all-zero vector yields a single flagged beat.
module onehot_drain_encoder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IDX_W     = $clog2(WIDTH),
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_zero,
  output logic [IDX_W:0]   out_count
);

  localparam int unsigned CW = IDX_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             last_q, last_d;
  logic             zero_q, zero_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Later iterations win, so loop direction picks lowest or highest set bit.
  function automatic logic [IDX_W-1:0] sel_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    index_d   = index_q;
    last_d    = last_q;
    zero_d    = zero_q;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        if (in_valid && enable) begin
          state_d   = DRAIN;
          pending_d = in_vec;
          valid_d   = 1'b1;
          count_d   = popcount(in_vec);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (last_q) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            pending_d = '0;
          end else begin
            pending_d = pending_q & ~(WIDTH'(1) << index_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Beat fields for the next cycle come from the next pending value.
    if (state_d == DRAIN) begin
      index_d = sel_idx(pending_d);
      last_d  = (popcount(pending_d) <= CW'(1));
      zero_d  = (pending_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      last_q    <= 1'b0;
      zero_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      last_q    <= last_d;
      zero_q    <= zero_d;
      count_q   <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && enable;
  assign out_valid = valid_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign out_zero  = zero_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_onehot_drain_encoder.sv
// Directed bench for onehot_drain_encoder: an LSB-first and an MSB-first
// instance share clock, reset, enable, in_vec and out_ready.
module tb_onehot_drain_encoder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDX_W = 4;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] in_vec;
  logic             out_ready;

  logic             l_in_valid, l_in_ready, l_out_valid, l_out_last, l_out_zero;
  logic [IDX_W-1:0] l_out_index;
  logic [IDX_W:0]   l_out_count;

  logic             m_in_valid, m_in_ready, m_out_valid, m_out_last, m_out_zero;
  logic [IDX_W-1:0] m_out_index;
  logic [IDX_W:0]   m_out_count;

  int checks;
  int errors;

  onehot_drain_encoder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_vec(in_vec),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_index(l_out_index),
    .out_last(l_out_last), .out_zero(l_out_zero), .out_count(l_out_count)
  );

  onehot_drain_encoder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_index(m_out_index),
    .out_last(m_out_last), .out_zero(m_out_zero), .out_count(m_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector to one instance for a single edge; outputs then show beat 1.
  task automatic accept(input logic [WIDTH-1:0] v, input bit msb);
    in_vec = v;
    if (msb) m_in_valid = 1'b1; else l_in_valid = 1'b1;
    tick();
    l_in_valid = 1'b0;
    m_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (l_out_valid !== 1'b0 || l_out_index !== 4'd0 || l_out_last !== 1'b0 ||
        l_out_zero !== 1'b0 || l_out_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b idx=%0d last=%b zero=%b cnt=%0d, want all 0",
               l_out_valid, l_out_index, l_out_last, l_out_zero, l_out_count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (l_in_ready !== 1'b1 || m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: lsb=%b msb=%b, want 1", l_in_ready, m_in_ready);
    end
  endtask

  task automatic test_onehot();
    accept(16'h0400, 1'b0);
    checks++;
    if (l_out_valid !== 1'b1 || l_out_index !== 4'd10 || l_out_last !== 1'b1 ||
        l_out_count !== 5'd1 || l_out_zero !== 1'b0) begin
      errors++;
      $display("FAIL onehot_0400: valid=%b idx=%0d last=%b cnt=%0d zero=%b, want 1 10 1 1 0",
               l_out_valid, l_out_index, l_out_last, l_out_count, l_out_zero);
    end
    tick();
    for (int i = 0; i < WIDTH; i++) begin
      accept(WIDTH'(1) << i, 1'b0);
      checks++;
      if (l_out_valid !== 1'b1 || l_out_index !== IDX_W'(i) || l_out_last !== 1'b1 ||
          l_out_count !== 5'd1) begin
        errors++;
        $display("FAIL onehot_sweep bit %0d: valid=%b idx=%0d last=%b cnt=%0d",
                 i, l_out_valid, l_out_index, l_out_last, l_out_count);
      end
      tick();
      checks++;
      if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL onehot_return bit %0d: valid=%b in_ready=%b, want 0 1",
                 i, l_out_valid, l_in_ready);
      end
    end
  endtask

  task automatic test_multi_lsb();
    logic [IDX_W-1:0] exp_idx [4];
    exp_idx[0] = 4'd0;
    exp_idx[1] = 4'd5;
    exp_idx[2] = 4'd10;
    exp_idx[3] = 4'd15;
    accept(16'h8421, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (l_out_valid !== 1'b1 || l_out_index !== exp_idx[k] ||
          l_out_last !== (k == 3) || l_out_count !== 5'd4 || l_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL multi_lsb beat %0d: valid=%b idx=%0d last=%b cnt=%0d rdy=%b, want idx %0d cnt 4",
                 k, l_out_valid, l_out_index, l_out_last, l_out_count, l_in_ready, exp_idx[k]);
      end
      tick();
    end
    checks++;
    if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL multi_lsb_end: valid=%b in_ready=%b, want 0 1", l_out_valid, l_in_ready);
    end
  endtask

  task automatic test_multi_msb();
    accept(16'hFFFF, 1'b1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (m_out_valid !== 1'b1 || m_out_index !== IDX_W'(15 - k) ||
          m_out_last !== (k == 15) || m_out_count !== 5'd16) begin
        errors++;
        $display("FAIL multi_msb beat %0d: valid=%b idx=%0d last=%b cnt=%0d, want idx %0d cnt 16",
                 k, m_out_valid, m_out_index, m_out_last, m_out_count, 15 - k);
      end
      tick();
    end
    checks++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL multi_msb_end: valid=%b in_ready=%b, want 0 1", m_out_valid, m_in_ready);
    end
  endtask

  task automatic test_zero_enable();
    accept(16'h0000, 1'b0);
    checks++;
    if (l_out_valid !== 1'b1 || l_out_index !== 4'd0 || l_out_zero !== 1'b1 ||
        l_out_last !== 1'b1 || l_out_count !== 5'd0) begin
      errors++;
      $display("FAIL zero_beat: valid=%b idx=%0d zero=%b last=%b cnt=%0d, want 1 0 1 1 0",
               l_out_valid, l_out_index, l_out_zero, l_out_last, l_out_count);
    end
    tick();
    checks++;
    if (l_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_single: valid=%b, want 0", l_out_valid);
    end
    enable = 1'b0;
    in_vec = 16'h0003;
    l_in_valid = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (l_in_ready !== 1'b0 || l_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL enable_block cycle %0d: in_ready=%b valid=%b, want 0 0",
                 c, l_in_ready, l_out_valid);
      end
      tick();
    end
    l_in_valid = 1'b0;
    enable = 1'b1;
    #1;
    checks++;
    if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_restore: in_ready=%b valid=%b, want 1 0", l_in_ready, l_out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    accept(16'h0006, 1'b0);
    in_vec = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (l_out_valid !== 1'b1 || l_out_index !== 4'd1 || l_out_last !== 1'b0 ||
          l_out_count !== 5'd2) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: valid=%b idx=%0d last=%b cnt=%0d, want 1 1 0 2",
                 c, l_out_valid, l_out_index, l_out_last, l_out_count);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (l_out_index !== 4'd1 || l_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_first: valid=%b idx=%0d, want 1 1", l_out_valid, l_out_index);
    end
    tick();
    checks++;
    if (l_out_valid !== 1'b1 || l_out_index !== 4'd2 || l_out_last !== 1'b1 ||
        l_out_count !== 5'd2) begin
      errors++;
      $display("FAIL backpressure_second: valid=%b idx=%0d last=%b cnt=%0d, want 1 2 1 2",
               l_out_valid, l_out_index, l_out_last, l_out_count);
    end
    tick();
    checks++;
    if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_end: valid=%b in_ready=%b, want 0 1", l_out_valid, l_in_ready);
    end
  endtask

  task automatic test_reset_mid_drain();
    accept(16'h00F0, 1'b0);
    checks++;
    if (l_out_index !== 4'd4) begin
      errors++;
      $display("FAIL midrst_beat1: idx=%0d, want 4", l_out_index);
    end
    tick();
    checks++;
    if (l_out_index !== 4'd5 || l_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_beat2: valid=%b idx=%0d, want 1 5", l_out_valid, l_out_index);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (l_out_valid !== 1'b0 || l_out_count !== 5'd0 || l_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after: valid=%b cnt=%0d in_ready=%b, want 0 0 1",
               l_out_valid, l_out_count, l_in_ready);
    end
    accept(16'h0001, 1'b0);
    checks++;
    if (l_out_valid !== 1'b1 || l_out_index !== 4'd0 || l_out_last !== 1'b1 ||
        l_out_count !== 5'd1) begin
      errors++;
      $display("FAIL midrst_new: valid=%b idx=%0d last=%b cnt=%0d, want 1 0 1 1",
               l_out_valid, l_out_index, l_out_last, l_out_count);
    end
    tick();
    checks++;
    if (l_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_new_end: valid=%b, want 0", l_out_valid);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    enable     = 1'b1;
    in_vec     = '0;
    out_ready  = 1'b1;
    l_in_valid = 1'b0;
    m_in_valid = 1'b0;
    test_reset();
    test_onehot();
    test_multi_lsb();
    test_multi_msb();
    test_zero_enable();
    test_backpressure();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
